mouse_receiver: RTL and testbench

MOUSE_RECEIVER -- requirements
Module: mouse_receiver

---
 rtl/mouse_receiver_pkg.sv | 20 ++
 rtl/mouse_receiver_if.sv | 32 +++
 rtl/ps2_sync_edge.sv | 26 ++
 rtl/mouse_receiver.sv | 141 ++++++++++++++
 tb/tb_mouse_receiver.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mouse_receiver_pkg.sv
// Shared definitions for the PS/2 mouse byte receiver.
//   - rx_state_e        : receiver FSM state encoding
//   - ErrParityIdx/Stop : bit positions inside BYTE_ERROR_CODE
//   - TimeoutCyclesDefault : default inter-edge timeout (200 us at 50 MHz)
package mouse_receiver_pkg;

  localparam int unsigned TimeoutCyclesDefault = 10000;

  localparam int unsigned ErrParityIdx = 0;
  localparam int unsigned ErrStopIdx   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

endpackage

// File: rtl/mouse_receiver_if.sv
// PS/2 receive bus bundle.
//   master : mouse/line side (drives PS/2 lines and READ_ENABLE, observes results)
//   slave  : receiver side (samples PS/2 lines, drives BYTE_READ/BYTE_ERROR_CODE/BYTE_READY)
// The receiver only ever reads the PS/2 lines; it never drives them.
interface mouse_receiver_if;

  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output CLK_MOUSE_IN,
    output DATA_MOUSE_IN,
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  modport slave (
    input  CLK_MOUSE_IN,
    input  DATA_MOUSE_IN,
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer plus one history flop for falling-edge detection.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset (flops reset to 1, the idle line level)
//   line_i : asynchronous input line
//   fall_o : one-cycle pulse when the synchronized line goes 1 -> 0
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic fall_o
);

  // [0],[1] synchronizer, [2] previous synchronized value
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], line_i};
    end
  end

  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 mouse byte receiver: start bit, 8 data bits LSB-first, odd parity, stop bit.
//   CLK     : 50 MHz system clock
//   RESET   : asynchronous active-low reset
//   bus_io  : slave side of mouse_receiver_if
//     CLK_MOUSE_IN/DATA_MOUSE_IN : asynchronous PS/2 lines (input only)
//     READ_ENABLE                : permits a new frame to start
//     BYTE_READ                  : last received byte
//     BYTE_ERROR_CODE            : bit0 parity error, bit1 stop-bit error
//     BYTE_READY                 : one-cycle pulse, outputs valid
// A frame that stalls for TIMEOUT_CYCLES between PS/2 clock falls is dropped silently.
module mouse_receiver
  import mouse_receiver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic             CLK,
  input  logic             RESET,
  mouse_receiver_if.slave  bus_io
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic clk_fall;
  logic [1:0] data_sync_q;
  logic data_s;

  rx_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0] shift_q, shift_d;
  logic par_err_q, par_err_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] code_q, code_d;

  ps2_sync_edge u_clk_sync (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .line_i (bus_io.CLK_MOUSE_IN),
    .fall_o (clk_fall)
  );

  // Two flops give the same latency as the clock line's synchronized value,
  // so data_s is the level present when the fall is detected.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_sync_q <= 2'b11;
    end else begin
      data_sync_q <= {data_sync_q[0], bus_io.DATA_MOUSE_IN};
    end
  end

  assign data_s = data_sync_q[1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      shift_q   <= 8'h00;
      par_err_q <= 1'b0;
      byte_q    <= 8'h00;
      code_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      byte_q    <= byte_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    byte_d    = byte_q;
    code_d    = code_q;

    unique case (state_q)
      StIdle: begin
        if (clk_fall && !data_s && bus_io.READ_ENABLE) begin
          state_d   = StData;
          bit_cnt_d = '0;
          tmo_d     = '0;
          par_err_d = 1'b0;
        end
      end

      StData, StParity, StStop: begin
        if (clk_fall) begin
          // A fall always beats an expiring timeout.
          tmo_d = '0;
          unique case (state_q)
            StData: begin
              shift_d   = {data_s, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_d = StParity;
              end
            end
            StParity: begin
              par_err_d = ~(^shift_q ^ data_s);
              state_d   = StStop;
            end
            default: begin
              // Stop bit: results are latched here so they are valid during
              // the DONE cycle that raises BYTE_READY.
              byte_d               = shift_q;
              code_d[ErrParityIdx] = par_err_q;
              code_d[ErrStopIdx]   = ~data_s;
              state_d              = StDone;
            end
          endcase
        end else if (tmo_q == TmoLast) begin
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus_io.BYTE_READ       = byte_q;
  assign bus_io.BYTE_ERROR_CODE = code_q;
  assign bus_io.BYTE_READY      = (state_q == StDone);

endmodule

// File: tb/tb_mouse_receiver.sv
// Scoreboard bench for mouse_receiver. PS/2 timing is scaled down (bit period
// 100 CLK cycles, timeout 300 cycles) to keep the run short; ratios between bit
// period, timeout and stall length follow the 60 us / 200 us / 250 us scenario.
module tb_mouse_receiver;

  localparam int unsigned TimeoutCycles = 300;
  localparam int unsigned HalfBit       = 50;
  localparam int unsigned StallCycles   = 400;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] code;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #10 clk = ~clk;

  mouse_receiver_if bus ();

  mouse_receiver #(
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .bus_io (bus)
  );

  exp_t sb_q[$];
  exp_t mon_exp;
  int   errors    = 0;
  int   checks    = 0;
  int   ready_cnt = 0;
  logic ready_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every BYTE_READY pulse pops the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && bus.BYTE_READY) begin
      ready_cnt <= ready_cnt + 1;
      check_eq("ready_width", 32'(ready_prev), 32'd0);
      check_eq("ready_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        check_eq("byte_read", 32'(bus.BYTE_READ), 32'(mon_exp.data));
        check_eq("error_code", 32'(bus.BYTE_ERROR_CODE), 32'(mon_exp.code));
      end
    end
    ready_prev <= bus.BYTE_READY;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic expect_frame(input logic [7:0] b, input logic [1:0] code);
    exp_t e;
    e.data = b;
    e.code = code;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_byte"}, 32'(bus.BYTE_READ), 32'h00);
    check_eq({tag, "_code"}, 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check_eq({tag, "_ready"}, 32'(bus.BYTE_READY), 32'h0);
  endtask

  // Data changes mid-high-phase, then the PS/2 clock goes low for half a bit.
  task automatic ps2_bit(input logic b);
    wait_cyc(HalfBit / 2);
    bus.DATA_MOUSE_IN = b;
    wait_cyc(HalfBit / 2);
    bus.CLK_MOUSE_IN = 1'b0;
    wait_cyc(HalfBit);
    bus.CLK_MOUSE_IN = 1'b1;
  endtask

  // n_edges: how many of the 11 bits to clock; re_drop_after / rst_after:
  // bit index after which READ_ENABLE drops / RESET pulses (-1 = never).
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int n_edges, input int re_drop_after, input int rst_after);
    logic [10:0] bits;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < n_edges; i++) begin
      ps2_bit(bits[i]);
      if (i == re_drop_after) bus.READ_ENABLE = 1'b0;
      if (i == rst_after) begin
        rst_n = 1'b0;
        wait_cyc(5);
        check_reset_outputs("midframe_reset");
        rst_n = 1'b1;
      end
    end
    wait_cyc(HalfBit);
    bus.DATA_MOUSE_IN = 1'b1;
    wait_cyc(HalfBit);
  endtask

  initial begin
    bus.CLK_MOUSE_IN  = 1'b1;
    bus.DATA_MOUSE_IN = 1'b1;
    bus.READ_ENABLE   = 1'b1;
    wait_cyc(5);
    check_reset_outputs("por");
    rst_n = 1'b1;
    wait_cyc(20);

    // Clean frame, parity error, stop-bit error.
    expect_frame(8'hFA, 2'b00);
    send_frame(8'hFA, odd_par(8'hFA), 1'b1, 11, -1, -1);
    expect_frame(8'hFA, 2'b01);
    send_frame(8'hFA, ~odd_par(8'hFA), 1'b1, 11, -1, -1);
    expect_frame(8'hAA, 2'b10);
    send_frame(8'hAA, odd_par(8'hAA), 1'b0, 11, -1, -1);

    // Stall after 4 data bits: timeout, no pulse, outputs unchanged.
    send_frame(8'h55, odd_par(8'h55), 1'b1, 5, -1, -1);
    wait_cyc(StallCycles);
    check_eq("timeout_ready_cnt", 32'(ready_cnt), 32'd3);
    check_eq("timeout_byte_hold", 32'(bus.BYTE_READ), 32'hAA);
    check_eq("timeout_code_hold", 32'(bus.BYTE_ERROR_CODE), 32'h2);
    expect_frame(8'hAA, 2'b00);
    send_frame(8'hAA, odd_par(8'hAA), 1'b1, 11, -1, -1);

    // READ_ENABLE low for a whole frame: ignored.
    bus.READ_ENABLE = 1'b0;
    send_frame(8'hFA, odd_par(8'hFA), 1'b1, 11, -1, -1);
    wait_cyc(StallCycles);
    check_eq("re_low_ready_cnt", 32'(ready_cnt), 32'd4);
    check_eq("re_low_byte_hold", 32'(bus.BYTE_READ), 32'hAA);
    bus.READ_ENABLE = 1'b1;

    // READ_ENABLE dropped after data bit 3 (bit index 4) does not abort.
    expect_frame(8'h00, 2'b00);
    send_frame(8'h00, odd_par(8'h00), 1'b1, 11, 4, -1);
    bus.READ_ENABLE = 1'b1;

    // Reset after data bit 5 (bit index 6): partial frame discarded.
    send_frame(8'hFA, odd_par(8'hFA), 1'b1, 11, -1, 6);
    wait_cyc(StallCycles);
    check_eq("reset_ready_cnt", 32'(ready_cnt), 32'd5);
    check_reset_outputs("after_reset_frame");
    expect_frame(8'hFA, 2'b00);
    send_frame(8'hFA, odd_par(8'hFA), 1'b1, 11, -1, -1);

    wait_cyc(100);
    check_eq("final_ready_cnt", 32'(ready_cnt), 32'd6);
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(200_000 * 20);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
